// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises the serial line, validates the start bit and strobes each bit centre.
// Optional macro UART_RX_MAJORITY_EN: decide each bit by 2-of-3 vote over the last three oversample ticks.
module uart_rx_sampler #(
    parameter int unsigned OS_DIV      = 27,
    parameter int unsigned OSR         = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rxd_raw,
    output logic       o_clk_rx,
    output logic       o_rxd,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    localparam int TW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int SW = $clog2(OSR);
    localparam logic [TW-1:0] TICK_MAX = TW'(OS_DIV - 1);
    localparam logic [SW-1:0] SAMP_MID = SW'(OSR / 2 - 1);
    localparam logic [SW-1:0] SAMP_MAX = SW'(OSR - 1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxd_prev_q, rxd_prev_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [SW-1:0]          samp_q, samp_d;
    logic [2:0]             bit_q, bit_d;
    logic                   rxd_hold_q, rxd_hold_d;

    logic rxd_s;
    logic os_tick;
    logic sample;
    logic strobe;
    logic ferr;

    assign rxd_s   = sync_q[SYNC_STAGES-1];
    assign os_tick = (state_q != ST_IDLE) && (tick_q == TICK_MAX);

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], i_rxd_raw};
        rxd_prev_d = rxd_s;
    end

`ifdef UART_RX_MAJORITY_EN
    // Levels seen at the two previous oversample ticks; vote together with the current one.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (os_tick) begin
            hist_d = {hist_q[0], rxd_s};
        end
        sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    always_comb begin
        sample = rxd_s;
    end
`endif

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        rxd_hold_d = rxd_hold_q;
        strobe     = 1'b0;
        ferr       = 1'b0;

        if (state_q != ST_IDLE) begin
            tick_d = os_tick ? '0 : tick_q + 1'b1;
            if (os_tick) begin
                samp_d = (samp_q == SAMP_MAX) ? '0 : samp_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Counters sit at zero here, so entry to START begins a fresh bit period.
                tick_d = '0;
                samp_d = '0;
                bit_d  = '0;
                if (rxd_prev_q && !rxd_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (os_tick && (samp_q == SAMP_MID)) begin
                    if (!sample) begin
                        strobe  = 1'b1;
                        samp_d  = '0;
                        bit_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (os_tick && (samp_q == SAMP_MAX)) begin
                    strobe = 1'b1;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (os_tick && (samp_q == SAMP_MAX)) begin
                    strobe  = 1'b1;
                    ferr    = !sample;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (strobe) begin
            rxd_hold_d = sample;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sync_q     <= '1;
            rxd_prev_q <= 1'b1;
            tick_q     <= '0;
            samp_q     <= '0;
            bit_q      <= '0;
            rxd_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            rxd_prev_q <= rxd_prev_d;
            tick_q     <= tick_d;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            rxd_hold_q <= rxd_hold_d;
        end
    end

    // Strobes come straight from registered state; reset masks them within the same cycle.
    assign o_clk_rx    = strobe & ~reset;
    assign o_frame_err = ferr & ~reset;
    assign o_rxd       = o_clk_rx ? sample : rxd_hold_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_dbg_state = state_q;

endmodule
